// File: rtl/rf_sequencer.sv
// rf_sequencer: multi-cycle control sequencer feeding the 8x10-bit register file.
// Latches one instruction per Run handshake, walks
// IDLE -> DECODE -> (EXEC | IMM_WAIT) -> WB -> DONE, and drives the register-file
// read/write controls as Moore outputs decoded from state and the latched instruction.
// Optional feature macro: RF_SEQ_TIMEOUT_EN bounds the IMM_WAIT state to IMM_TIMEOUT
// cycles; a timed-out mvi retires with Err and without a write.
module rf_sequencer #(
    parameter int DW          = 10,
    parameter int AW          = 3,
    parameter int CNTW        = 16,
    parameter int IMM_TIMEOUT = 15
) (
    input  logic            CLKb,
    input  logic            RST,
    input  logic            Run,
    input  logic [DW-1:0]   Instr,
    input  logic [DW-1:0]   Din,
    input  logic            DinValid,
    output logic            ENW,
    output logic [AW-1:0]   WRA,
    output logic            ENR0,
    output logic            ENR1,
    output logic [AW-1:0]   RDA0,
    output logic [AW-1:0]   RDA1,
    output logic [1:0]      DSEL,
    output logic            ALU_SUB,
    output logic            ALOAD,
    output logic [DW-1:0]   IMM,
    output logic            Busy,
    output logic            Done,
    output logic            Err,
    output logic [CNTW-1:0] ICOUNT
);
    typedef enum logic [2:0] {
        S_IDLE, S_DECODE, S_EXEC, S_IMM_WAIT, S_WB, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   ir_q, ir_d;
    logic [DW-1:0]   imm_q, imm_d;
    logic [CNTW-1:0] icount_q, icount_d;
    logic            timed_out;

    // Instruction fields; bit 9 is reserved and deliberately ignored.
    logic [2:0]    op;
    logic [AW-1:0] rx, ry;
    logic          unused_rsvd;
    assign op          = ir_q[8:6];
    assign rx          = ir_q[5:3];
    assign ry          = ir_q[2:0];
    assign unused_rsvd = ir_q[DW-1];

`ifdef RF_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(IMM_TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tout_q, tout_d;

    // IMM_WAIT watchdog: cleared while decoding, counts each IMM_WAIT cycle, and
    // flags the instruction once the last allowed cycle passes without DinValid.
    always_comb begin
        tmo_d  = tmo_q;
        tout_d = tout_q;
        if (state_q == S_DECODE) begin
            tmo_d  = '0;
            tout_d = 1'b0;
        end else if (state_q == S_IMM_WAIT) begin
            tmo_d = tmo_q + TW'(1);
            if (!DinValid && tmo_q == TW'(IMM_TIMEOUT - 1))
                tout_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge CLKb) begin
        if (RST) begin
            tmo_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            tout_q <= tout_d;
        end
    end

    assign timed_out = tout_q;
`else
    assign timed_out = 1'b0;
`endif

    // Next-state and datapath-register update.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        imm_d    = imm_q;
        icount_d = icount_q;
        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    ir_d    = Instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op[2])                state_d = S_DONE;
                else if (op[1:0] == 2'b00) state_d = S_WB;
                else if (op[1:0] == 2'b01) state_d = S_IMM_WAIT;
                else                       state_d = S_EXEC;
            end
            S_EXEC: state_d = S_WB;
            S_IMM_WAIT: begin
                if (DinValid) begin
                    imm_d   = Din;
                    state_d = S_WB;
                end
`ifdef RF_SEQ_TIMEOUT_EN
                else if (tmo_q == TW'(IMM_TIMEOUT - 1)) begin
                    state_d = S_DONE;
                end
`endif
            end
            S_WB: state_d = S_DONE;
            S_DONE: begin
                if (!op[2] && !timed_out)
                    icount_d = icount_q + CNTW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLKb) begin
        if (RST) begin
            state_q  <= S_IDLE;
            ir_q     <= '0;
            imm_q    <= '0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            imm_q    <= imm_d;
            icount_q <= icount_d;
        end
    end

    // Moore register-file controls decoded from state and latched instruction.
    always_comb begin
        ENW     = 1'b0;
        WRA     = '0;
        ENR0    = 1'b0;
        ENR1    = 1'b0;
        RDA0    = '0;
        RDA1    = '0;
        DSEL    = 2'b00;
        ALU_SUB = 1'b0;
        ALOAD   = 1'b0;
        Done    = 1'b0;
        Err     = 1'b0;
        Busy    = (state_q != S_IDLE);
        case (state_q)
            S_DECODE: begin
                ENR0 = 1'b1;
                ENR1 = 1'b1;
                RDA0 = rx;
                RDA1 = ry;
            end
            S_EXEC: begin
                ENR0    = 1'b1;
                ENR1    = 1'b1;
                RDA0    = rx;
                RDA1    = ry;
                ALOAD   = 1'b1;
                ALU_SUB = (op == 3'b011);
            end
            S_WB: begin
                ENW = 1'b1;
                WRA = rx;
                if (op == 3'b000)      DSEL = 2'b10;
                else if (op == 3'b001) DSEL = 2'b01;
                else                   DSEL = 2'b00;
            end
            S_DONE: begin
                Done = 1'b1;
                Err  = op[2] | timed_out;
            end
            default: ;
        endcase
    end

    assign IMM    = imm_q;
    assign ICOUNT = icount_q;

endmodule

// File: tb/tb_rf_sequencer.sv
// Scoreboard bench for rf_sequencer: the driver pushes an expected retire record
// (write target, mux select, error, retire cycle) per accepted instruction; a
// negedge monitor compares DUT controls against the head record.
module tb_rf_sequencer;
    localparam int CNTW_T = 4;
    localparam int TMO    = 15;
`ifdef RF_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        CLKb = 1'b0;
    logic        RST = 1'b1, Run = 1'b0, DinValid = 1'b0;
    logic [9:0]  Instr = '0, Din = '0;
    logic        ENW, ENR0, ENR1, ALU_SUB, ALOAD, Busy, Done, Err;
    logic [2:0]  WRA, RDA0, RDA1;
    logic [1:0]  DSEL;
    logic [9:0]  IMM;
    logic [CNTW_T-1:0] ICOUNT;

    rf_sequencer #(.DW(10), .AW(3), .CNTW(CNTW_T), .IMM_TIMEOUT(TMO)) dut (
        .CLKb(CLKb), .RST(RST), .Run(Run), .Instr(Instr), .Din(Din), .DinValid(DinValid),
        .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .ENR1(ENR1), .RDA0(RDA0), .RDA1(RDA1),
        .DSEL(DSEL), .ALU_SUB(ALU_SUB), .ALOAD(ALOAD), .IMM(IMM), .Busy(Busy),
        .Done(Done), .Err(Err), .ICOUNT(ICOUNT)
    );

    always #5 CLKb = ~CLKb;

    typedef struct {
        int         acc;     // cycle in which DECODE is expected
        int         done_c;  // cycle in which Done is expected
        logic [2:0] op, rx, ry;
        bit         wr, err, imm_ok;
        logic [9:0] din;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0, checks = 0, errors = 0;
    int   model_cnt = 0, done_cnt = 0, enw_cnt = 0, exp_done = 0, exp_enw = 0;
    logic [9:0] model_imm = '0;
    bit   in_rst = 1'b1;

    always @(posedge CLKb) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every cycle against the head of the scoreboard.
    exp_t e;
    always @(negedge CLKb) begin
        if (!in_rst) begin
            bit act;
            act = (sb.size() > 0) && (cyc >= sb[0].acc);
            if (act) e = sb[0];
            chk("busy", Busy, act);
            chk("icount", ICOUNT, model_cnt[CNTW_T-1:0]);
            if (act && cyc == e.acc) begin
                chk("decode_enr", {ENR0, ENR1}, 2'b11);
                chk("decode_rda", {RDA0, RDA1}, {e.rx, e.ry});
            end
            if (act && cyc == e.acc + 1 && e.op[2:1] == 2'b01) begin
                chk("exec_aload", ALOAD, 1'b1);
                chk("exec_sub", ALU_SUB, e.op == 3'b011);
                chk("exec_rda", {RDA0, RDA1}, {e.rx, e.ry});
            end
            if (ENW) begin
                enw_cnt++;
                if (act && e.wr && cyc == e.done_c - 1) begin
                    chk("wb_wra", WRA, e.rx);
                    chk("wb_dsel", DSEL, (e.op == 3'b000) ? 2'b10 : (e.op == 3'b001) ? 2'b01 : 2'b00);
                end else chk("enw_unexpected", 1, 0);
            end else if (act && e.wr && cyc == e.done_c - 1) chk("enw_missing", 0, 1);
            if (Done) begin
                done_cnt++;
                if (act && cyc == e.done_c) begin
                    chk("err", Err, e.err);
                    if (e.imm_ok) model_imm = e.din;
                    chk("imm", IMM, model_imm);
                    if (!e.err) model_cnt = (model_cnt + 1) % (1 << CNTW_T);
                    void'(sb.pop_front());
                end else chk("done_unexpected", 1, 0);
            end else begin
                if (Err) chk("err_without_done", 1, 0);
                if (act && cyc == e.done_c) begin
                    chk("done_missing", 0, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Issue one instruction at the next edge and drive it through retirement.
    // waits = IMM_WAIT cycles before DinValid; hold keeps Run high; spam pulses Run while busy.
    task automatic issue(input logic [9:0] ins, input int waits, input logic [9:0] din,
                         input bit hold, input bit spam);
        exp_t x;
        int   lat;
        bit   tmo;
        x.op = ins[8:6]; x.rx = ins[5:3]; x.ry = ins[2:0]; x.din = din;
        tmo = TMO_EN && (x.op == 3'b001) && (waits >= TMO);
        if (x.op[2])             lat = 2;
        else if (x.op == 3'b000) lat = 3;
        else if (x.op == 3'b001) lat = tmo ? 2 + TMO : 4 + waits;
        else                     lat = 4;
        x.acc    = cyc + 1;
        x.done_c = x.acc + lat - 1;
        x.err    = x.op[2] || tmo;
        x.wr     = !x.err;
        x.imm_ok = (x.op == 3'b001) && !tmo;
        sb.push_back(x);
        exp_done++;
        if (x.wr) exp_enw++;
        Run = 1'b1; Instr = ins; DinValid = 1'b0;
        @(posedge CLKb); #1;
        while (cyc < x.acc + lat) begin
            Run   = hold ? 1'b1 : (spam ? 1'($urandom_range(0, 1)) : 1'b0);
            Instr = 10'($urandom);
            if (x.op == 3'b001 && cyc == x.acc + 1 + waits) begin
                DinValid = 1'b1; Din = din;
            end else begin
                DinValid = 1'b0; Din = 10'($urandom);
            end
            @(posedge CLKb); #1;
        end
        Run = 1'b0; DinValid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {ENW, WRA, ENR0, ENR1, RDA0, RDA1, DSEL, ALU_SUB, ALOAD, Busy, Done, Err}, 0);
        chk({tag, "_imm"}, IMM, 0);
        chk({tag, "_icount"}, ICOUNT, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0] ins;
        int r;
        repeat (3) @(posedge CLKb);
        @(negedge CLKb); check_zero("reset");
        #1 RST = 1'b0; in_rst = 1'b0;
        @(posedge CLKb); #1;

        // Reset asserted for two edges while an add sits in EXEC.
        sb.push_back('{acc: cyc + 1, done_c: cyc + 4, op: 3'b010, rx: 3'd3, ry: 3'd4,
                       wr: 1'b1, err: 1'b0, imm_ok: 1'b0, din: '0});
        Run = 1'b1; Instr = 10'b0_010_011_100;
        @(posedge CLKb); #1 Run = 1'b0;
        @(posedge CLKb);
        @(negedge CLKb); #1;
        in_rst = 1'b1; RST = 1'b1; sb.delete();
        repeat (2) begin @(negedge CLKb); check_zero("midrst"); end
        #1 RST = 1'b0; model_cnt = 0; model_imm = '0; in_rst = 1'b0;
        @(posedge CLKb); #1;

        issue(10'b0_010_001_010, 0, '0, 1'b0, 1'b0);      // add R1,R2
        repeat (2) @(posedge CLKb); #1;
        issue(10'b0_001_101_000, 3, 10'h2A5, 1'b0, 1'b0); // mvi R5 after 3 idle cycles
        issue(10'b0_100_000_000, 0, '0, 1'b0, 1'b1);      // illegal, Run re-pulsed while busy
        issue(10'b1_111_010_001, 0, '0, 1'b0, 1'b1);      // illegal, reserved bit set
        issue(10'b0_010_011_011, 0, '0, 1'b0, 1'b0);      // add R3,R3
        issue(10'b0_011_110_110, 0, '0, 1'b0, 1'b0);      // sub R6,R6
        issue(10'b0_001_000_000, 0, 10'h155, 1'b0, 1'b0); // mvi, DinValid already high on entry
        for (int i = 0; i < 10; i++)                      // Run held, alternating mv/sub
            issue({1'b0, (i % 2) ? 3'b011 : 3'b000, 3'(i), 3'(i + 3)}, 0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 36; i++) begin
            r = $urandom_range(0, 9);
            ins = {1'($urandom), 3'b000, 3'($urandom), 3'($urandom)};
            ins[8:6] = (r >= 8) ? 3'($urandom_range(4, 7)) : 3'(r / 2);
            issue(ins, $urandom_range(0, 4), 10'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge CLKb);
            #1;
        end
        // mvi with DinValid withheld for 100 IMM_WAIT cycles (times out when enabled).
        issue(10'b0_001_111_010, 100, 10'h0C3, 1'b0, 1'b0);
        issue(10'b0_000_010_111, 0, '0, 1'b0, 1'b0);

        repeat (3) @(posedge CLKb);
        @(negedge CLKb);
        chk("sb_empty", sb.size(), 0);
        chk("done_total", done_cnt, exp_done);
        chk("enw_total", enw_cnt, exp_enw);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
